// File: rtl/pla_backward_slice_rd_sched_pkg.sv
// Shared definitions for the backward-slice read scheduler: FSM states,
// parameter defaults and the requester count.
package pla_backward_slice_rd_sched_pkg;

  localparam int unsigned NumReq       = 4;
  localparam int unsigned IdW          = 15;
  localparam int unsigned SliceWordsDef = 64;
  localparam int unsigned GapCyclesDef  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StResp,
    StRead,
    StGap
  } sched_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [NumReq-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pla_backward_slice_rd_sched_if.sv
// Requester-side bundle: per-xgmii requests and ids in, grant and burst strobes out.
interface pla_backward_slice_rd_sched_if;
  logic [3:0]  I_pla_rd_req;
  logic [59:0] I_pla_rd_req_id;
  logic [3:0]  O_pla_rd_ack;
  logic        O_pla_slice_rd_resp;
  logic [1:0]  O_pla_rd_xgmii_num;
  logic [14:0] O_pla_slice_rd_id;
  logic        O_pla_slice_data_rd;
  logic [5:0]  O_pla_slice_rd_word;

  modport master (
    output I_pla_rd_req, I_pla_rd_req_id,
    input  O_pla_rd_ack, O_pla_slice_rd_resp, O_pla_rd_xgmii_num, O_pla_slice_rd_id,
    input  O_pla_slice_data_rd, O_pla_slice_rd_word
  );

  modport slave (
    input  I_pla_rd_req, I_pla_rd_req_id,
    output O_pla_rd_ack, O_pla_slice_rd_resp, O_pla_rd_xgmii_num, O_pla_slice_rd_id,
    output O_pla_slice_data_rd, O_pla_slice_rd_word
  );
endinterface

// File: rtl/pla_rr_arb4.sv
// Combinational 4-way round-robin selector; search starts one past the last grant.
module pla_rr_arb4
  import pla_backward_slice_rd_sched_pkg::*;
(
  input  logic [NumReq-1:0] i_req,
  input  logic [1:0]        i_last_grant,
  output logic [NumReq-1:0] o_gnt,
  output logic              o_valid
);

  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // Offset NumReq wraps back to the last grantee, giving it lowest priority.
    for (int off = 1; off <= int'(NumReq); off++) begin
      w_idx = i_last_grant + 2'(off);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/pla_backward_slice_rd_sched.sv
// Grants one xgmii requester at a time a slice read: 2-cycle response window,
// SLICE_WORDS data strobes, then a quiet gap for the CRC pipeline to drain.
module pla_backward_slice_rd_sched
  import pla_backward_slice_rd_sched_pkg::*;
#(
  parameter int unsigned SLICE_WORDS = SliceWordsDef,
  parameter int unsigned GAP_CYCLES  = GapCyclesDef
) (
  input  logic        I_pla_312m5_clk,
  input  logic        I_pla_rst_n,
  input  logic        I_pla_sched_en,
  input  logic        I_pla_rd_cnt_clr,
  output logic        O_pla_sched_busy,
  output logic [15:0] O_pla_rd_slice_cnt,
  pla_backward_slice_rd_sched_if.slave rd_if
);

  localparam logic [5:0] LastWord = 6'(SLICE_WORDS - 1);
  // The IDLE arbitration cycle is the last quiet cycle, so GAP itself runs one short.
  localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 2);

  sched_state_e r_state;
  logic [3:0]   r_ack;
  logic         r_resp;
  logic         r_data_rd;
  logic [5:0]   r_word;
  logic [1:0]   r_num;
  logic [14:0]  r_id;
  logic         r_busy;
  logic [1:0]   r_last;
  logic [7:0]   r_cnt;
  logic [15:0]  r_slice_cnt;

  logic [3:0]   w_gnt;
  logic         w_valid;
  logic [1:0]   w_gnt_idx;
  logic [14:0]  w_gnt_id;
  logic         w_burst_done;

  pla_rr_arb4 u_arb (
    .i_req        (rd_if.I_pla_rd_req),
    .i_last_grant (r_last),
    .o_gnt        (w_gnt),
    .o_valid      (w_valid)
  );

  assign w_gnt_idx    = onehot_to_idx(w_gnt);
  assign w_gnt_id     = rd_if.I_pla_rd_req_id[IdW*w_gnt_idx +: IdW];
  assign w_burst_done = (r_state == StRead) && (r_word == LastWord);

  always_ff @(posedge I_pla_312m5_clk or negedge I_pla_rst_n) begin
    if (!I_pla_rst_n) begin
      r_state   <= StIdle;
      r_ack     <= '0;
      r_resp    <= 1'b0;
      r_data_rd <= 1'b0;
      r_word    <= '0;
      r_num     <= '0;
      r_id      <= '0;
      r_busy    <= 1'b0;
      r_last    <= 2'd3;
      r_cnt     <= '0;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        StIdle: begin
          if (I_pla_sched_en && w_valid) begin
            r_state <= StResp;
            r_ack   <= w_gnt;
            r_last  <= w_gnt_idx;
            r_num   <= w_gnt_idx;
            r_id    <= w_gnt_id;
            r_resp  <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        StResp: begin
          if (r_cnt == 8'd1) begin
            r_state   <= StRead;
            r_resp    <= 1'b0;
            r_data_rd <= 1'b1;
            r_word    <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StRead: begin
          if (r_word == LastWord) begin
            r_state   <= StGap;
            r_data_rd <= 1'b0;
            r_word    <= '0;
            r_cnt     <= '0;
          end else begin
            r_word <= r_word + 6'd1;
          end
        end
        StGap: begin
          if (r_cnt == GapLast) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge I_pla_312m5_clk or negedge I_pla_rst_n) begin
    if (!I_pla_rst_n) begin
      r_slice_cnt <= '0;
    end else if (I_pla_rd_cnt_clr) begin
      r_slice_cnt <= '0;
    end else if (w_burst_done && (r_slice_cnt != 16'hFFFF)) begin
      r_slice_cnt <= r_slice_cnt + 16'd1;
    end
  end

  assign rd_if.O_pla_rd_ack        = r_ack;
  assign rd_if.O_pla_slice_rd_resp = r_resp;
  assign rd_if.O_pla_rd_xgmii_num  = r_num;
  assign rd_if.O_pla_slice_rd_id   = r_id;
  assign rd_if.O_pla_slice_data_rd = r_data_rd;
  assign rd_if.O_pla_slice_rd_word = r_word;
  assign O_pla_sched_busy          = r_busy;
  assign O_pla_rd_slice_cnt        = r_slice_cnt;

endmodule
